// File: rtl/systolic_skew_buffer_if.sv
// Bus between the operand/result buffers and the skew buffer: stall/flush control,
// per-channel valid and packed data in, and per-channel delayed valid/data plus emptiness out.
interface systolic_skew_buffer_if #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 4
);
    logic                       enable_i;
    logic                       flush_i;
    logic [CHANNELS-1:0]        valid_i;
    logic [CHANNELS*DATA_W-1:0] data_i;
    logic [CHANNELS-1:0]        valid_o;
    logic [CHANNELS*DATA_W-1:0] data_o;
    logic                       empty_o;

    modport master (
        output enable_i, flush_i, valid_i, data_i,
        input  valid_o, data_o, empty_o
    );

    modport slave (
        input  enable_i, flush_i, valid_i, data_i,
        output valid_o, data_o, empty_o
    );
endinterface

// File: rtl/systolic_skew_buffer.sv
// Per-channel delay line that skews operands into (or deskews results out of) a systolic
// MAC array; every stage is a {valid, data} flop, with stall, flush and drain detection.
module systolic_skew_buffer #(
    parameter int DATA_W     = 16,
    parameter int CHANNELS   = 4,
    parameter int MODE       = 0,
    parameter int BASE_DELAY = 1
) (
    input  logic                 clock_i,
    input  logic                 resetn_i,
    systolic_skew_buffer_if.slave bus
);
    logic [CHANNELS-1:0]        last_valid;
    logic [CHANNELS*DATA_W-1:0] last_data;
    logic [CHANNELS-1:0]        ch_busy;

    if (BASE_DELAY < 1) begin : g_bad_base_delay
        $error("systolic_skew_buffer: BASE_DELAY must be >= 1");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("systolic_skew_buffer: CHANNELS must be >= 1");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // SKEW lengthens the line with channel index, DESKEW shortens it.
        localparam int DEPTH = (MODE == 0) ? BASE_DELAY + c
                                           : BASE_DELAY + (CHANNELS - 1 - c);

        logic [DEPTH-1:0]  vld_q;
        logic [DATA_W-1:0] dat_q [DEPTH];
        logic              in_valid;
        logic [DATA_W-1:0] in_data;

        // Bubbles carry a zero operand so the array edge sees a MAC-neutral value.
        assign in_valid = bus.valid_i[c];
        assign in_data  = in_valid ? bus.data_i[c*DATA_W +: DATA_W] : '0;

        // NOTE: the data stages are reset along with the valid bits, because an empty
        // slot must present data 0 at the output, not whatever was left in the flop.
        always_ff @(posedge clock_i or negedge resetn_i) begin
            if (!resetn_i) begin
                vld_q <= '0;
                for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
            end else if (bus.flush_i) begin
                vld_q <= '0;
                for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
            end else if (bus.enable_i) begin
                // NOTE: non-blocking assignments let every stage sample its neighbour's
                // old value, so the loop order does not matter.
                vld_q[0] <= in_valid;
                dat_q[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign last_valid[c]                   = vld_q[DEPTH-1];
        assign last_data[c*DATA_W +: DATA_W]   = dat_q[DEPTH-1];
        assign ch_busy[c]                      = |vld_q;
    end

    assign bus.valid_o = last_valid;
    assign bus.data_o  = last_data;
    assign bus.empty_o = ~|ch_busy;
endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Directed bench for systolic_skew_buffer: a SKEW and a DESKEW instance (4 channels,
// BASE_DELAY 1) share stimulus; outputs are sampled 1 time unit after each rising edge.
module tb_systolic_skew_buffer;
    localparam int DW = 16;
    localparam int CH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    systolic_skew_buffer_if #(.DATA_W(DW), .CHANNELS(CH)) bus_s ();
    systolic_skew_buffer_if #(.DATA_W(DW), .CHANNELS(CH)) bus_d ();

    systolic_skew_buffer #(.DATA_W(DW), .CHANNELS(CH), .MODE(0), .BASE_DELAY(1)) u_skew (
        .clock_i  (clk),
        .resetn_i (rst_n),
        .bus      (bus_s.slave)
    );

    systolic_skew_buffer #(.DATA_W(DW), .CHANNELS(CH), .MODE(1), .BASE_DELAY(1)) u_deskew (
        .clock_i  (clk),
        .resetn_i (rst_n),
        .bus      (bus_d.slave)
    );

    function automatic logic [63:0] pk(logic [15:0] d3, logic [15:0] d2,
                                       logic [15:0] d1, logic [15:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_s(input string tag, input logic [3:0] v, input logic [63:0] d,
                            input logic e);
        check({tag, " skew valid"}, 64'(bus_s.valid_o), 64'(v));
        check({tag, " skew data"},  bus_s.data_o, d);
        check({tag, " skew empty"}, 64'(bus_s.empty_o), 64'(e));
    endtask

    task automatic expect_d(input string tag, input logic [3:0] v, input logic [63:0] d,
                            input logic e);
        check({tag, " deskew valid"}, 64'(bus_d.valid_o), 64'(v));
        check({tag, " deskew data"},  bus_d.data_o, d);
        check({tag, " deskew empty"}, 64'(bus_d.empty_o), 64'(e));
    endtask

    task automatic drive(input logic en, input logic fl, input logic [3:0] v,
                         input logic [63:0] d);
        bus_s.enable_i = en; bus_s.flush_i = fl; bus_s.valid_i = v; bus_s.data_i = d;
        bus_d.enable_i = en; bus_d.flush_i = fl; bus_d.valid_i = v; bus_d.data_i = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with busy traffic on the inputs.
        drive(1'b1, 1'b0, 4'hF, {4{16'hFFFF}});
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b1, 1'b0, (i % 2 == 0) ? 4'h0 : 4'hF, {4{16'hFFFF}});
        end
        expect_s("reset", 4'h0, 64'h0, 1'b1);
        expect_d("reset", 4'h0, 64'h0, 1'b1);

        // Impulse: release reset and present the vector for edge 0.
        drive(1'b1, 1'b0, 4'hF, pk(16'h4, 16'h3, 16'h2, 16'h1));
        rst_n = 1'b1;
        tick();
        drive(1'b1, 1'b0, 4'h0, 64'h0);
        expect_s("imp e0", 4'b0001, pk(0, 0, 0, 16'h1), 1'b0);
        expect_d("imp e0", 4'b1000, pk(16'h4, 0, 0, 0), 1'b0);
        tick();
        expect_s("imp e1", 4'b0010, pk(0, 0, 16'h2, 0), 1'b0);
        expect_d("imp e1", 4'b0100, pk(0, 16'h3, 0, 0), 1'b0);
        tick();
        expect_s("imp e2", 4'b0100, pk(0, 16'h3, 0, 0), 1'b0);
        expect_d("imp e2", 4'b0010, pk(0, 0, 16'h2, 0), 1'b0);
        tick();
        expect_s("imp e3", 4'b1000, pk(16'h4, 0, 0, 0), 1'b0);
        expect_d("imp e3", 4'b0001, pk(0, 0, 0, 16'h1), 1'b0);
        tick();
        expect_s("imp e4", 4'h0, 64'h0, 1'b1);
        expect_d("imp e4", 4'h0, 64'h0, 1'b1);

        // Stall for two cycles after edge 1; junk on the inputs must be ignored.
        drive(1'b1, 1'b0, 4'hF, pk(16'h4, 16'h3, 16'h2, 16'h1));
        tick();
        drive(1'b1, 1'b0, 4'h0, 64'h0);
        expect_s("stall e0", 4'b0001, pk(0, 0, 0, 16'h1), 1'b0);
        tick();
        expect_s("stall e1", 4'b0010, pk(0, 0, 16'h2, 0), 1'b0);
        drive(1'b0, 1'b0, 4'hF, {4{16'h9999}});
        tick();
        expect_s("stall hold1", 4'b0010, pk(0, 0, 16'h2, 0), 1'b0);
        tick();
        expect_s("stall hold2", 4'b0010, pk(0, 0, 16'h2, 0), 1'b0);
        drive(1'b1, 1'b0, 4'h0, 64'h0);
        tick();
        expect_s("stall e2", 4'b0100, pk(0, 16'h3, 0, 0), 1'b0);
        tick();
        expect_s("stall e3", 4'b1000, pk(16'h4, 0, 0, 0), 1'b0);
        tick();
        expect_s("stall e4", 4'h0, 64'h0, 1'b1);

        // Stream three vectors, then flush together with a 0xAAAA vector.
        drive(1'b1, 1'b0, 4'hF, {4{16'h1111}});
        tick();
        drive(1'b1, 1'b0, 4'hF, {4{16'h2222}});
        tick();
        drive(1'b1, 1'b0, 4'hF, {4{16'h3333}});
        tick();
        expect_s("stream", 4'b0111, pk(0, 16'h1111, 16'h2222, 16'h3333), 1'b0);
        drive(1'b1, 1'b1, 4'hF, {4{16'hAAAA}});
        tick();
        drive(1'b1, 1'b0, 4'h0, 64'h0);
        expect_s("flush", 4'h0, 64'h0, 1'b1);
        expect_d("flush", 4'h0, 64'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_s($sformatf("post flush %0d", i), 4'h0, 64'h0, 1'b1);
            expect_d($sformatf("post flush %0d", i), 4'h0, 64'h0, 1'b1);
        end

        // DESKEW: channel c valid at edge c emerges aligned after edge 3.
        drive(1'b1, 1'b0, 4'b0001, pk(0, 0, 0, 16'h00B0));
        tick();
        drive(1'b1, 1'b0, 4'b0010, pk(0, 0, 16'h00B1, 0));
        tick();
        drive(1'b1, 1'b0, 4'b0100, pk(0, 16'h00B2, 0, 0));
        tick();
        expect_d("align e2", 4'h0, 64'h0, 1'b0);
        drive(1'b1, 1'b0, 4'b1000, pk(16'h00B3, 0, 0, 0));
        tick();
        drive(1'b1, 1'b0, 4'h0, 64'h0);
        expect_d("align e3", 4'hF, pk(16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0), 1'b0);
        tick();
        expect_d("align e4", 4'h0, 64'h0, 1'b1);
        tick();
        tick();
        tick();
        expect_s("align drained", 4'h0, 64'h0, 1'b1);

        // Partial mask: bubbles on ch1/ch3 must read as zero despite nonzero data_i.
        drive(1'b1, 1'b0, 4'b0101, {4{16'h1234}});
        tick();
        drive(1'b1, 1'b0, 4'h0, 64'h0);
        expect_s("mask e0", 4'b0001, pk(0, 0, 0, 16'h1234), 1'b0);
        tick();
        expect_s("mask e1", 4'h0, 64'h0, 1'b0);
        expect_d("mask e1", 4'b0100, pk(0, 16'h1234, 0, 0), 1'b0);
        tick();
        expect_s("mask e2", 4'b0100, pk(0, 16'h1234, 0, 0), 1'b0);
        tick();
        expect_s("mask e3", 4'h0, 64'h0, 1'b1);
        expect_d("mask e3", 4'b0001, pk(0, 0, 0, 16'h1234), 1'b0);

        // Asynchronous reset in the middle of traffic, between clock edges.
        drive(1'b1, 1'b0, 4'hF, pk(16'h5, 16'h6, 16'h7, 16'h8));
        tick();
        tick();
        expect_s("traffic", 4'b0011, pk(0, 0, 16'h7, 16'h8), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_s("async reset", 4'h0, 64'h0, 1'b1);
        expect_d("async reset", 4'h0, 64'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
